addsub_seq: RTL and testbench

Parametrised, multi-cycle two's-complement adder/subtractor for the Booth multiplier datapath and related arithmetic. It accepts one operand pair per transaction over a valid/ready handshake and processes CHUNK bits per clock, least-significant chunk first, holding the carry in a register between chunks. It returns the WIDTH-bit result with carry, signed-overflow and zero flags over a second valid/ready handshake. Setting CHUNK equal to WIDTH gives a single-cycle registered add/subtract; smaller CHUNK values trade latency for a narrower adder.

---
 rtl/addsub_seq.sv | 136 +++++++++++++
 tb/tb_addsub_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock, LSB chunk first,
// carry held between chunks; result and carry/overflow/zero flags returned over valid/ready.
module addsub_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LAST  = N - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cout_d, ovf_d, zero_d;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_shift;
  logic             last_chunk;

  // Operands shift right each cycle so the active chunk always sits in the low bits;
  // the result fills in from the top and is complete after N shifts.
  always_comb begin
    chunk_sum  = (CHUNK+1)'(a_q[CHUNK-1:0]) + (CHUNK+1)'(b_q[CHUNK-1:0]) + (CHUNK+1)'(carry_q);
    res_shift  = (result >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    last_chunk = (idx_q == IDX_W'(LAST));
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = result;
    cout_d  = cout;
    ovf_d   = ovf;
    zero_d  = zero;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
          carry_d = sub;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + IDX_W'(1);
        res_d   = res_shift;
        if (last_chunk) begin
          idx_d   = '0;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = (a_msb_q == b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
          zero_d  = (res_shift == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      result    <= res_d;
      cout      <= cout_d;
      ovf       <= ovf_d;
      zero      <= zero_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: directed 8/4 vectors, backpressure and reset corners,
// then randomized sweeps of three other WIDTH/CHUNK configurations against a model.
module tb_addsub_seq;

  localparam int unsigned NI = 4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] r;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_s  [NI];
  logic        out_ready_s [NI];
  logic        sub_s       [NI];
  logic [15:0] a_s         [NI];
  logic [15:0] b_s         [NI];
  wire         in_ready_s  [NI];
  wire         out_valid_s [NI];
  wire         cout_s      [NI];
  wire         ovf_s       [NI];
  wire         zero_s      [NI];
  wire  [15:0] res_s       [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s[0][7:0]), .b(b_s[0][7:0]), .sub(sub_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .result(res_s[0][7:0]), .cout(cout_s[0]),
    .ovf(ovf_s[0]), .zero(zero_s[0]));
  assign res_s[0][15:8] = '0;

  addsub_seq #(.WIDTH(16), .CHUNK(1)) u_w16c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s[1]), .b(b_s[1]), .sub(sub_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .result(res_s[1]), .cout(cout_s[1]),
    .ovf(ovf_s[1]), .zero(zero_s[1]));

  addsub_seq #(.WIDTH(16), .CHUNK(16)) u_w16c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .a(a_s[2]), .b(b_s[2]), .sub(sub_s[2]), .out_valid(out_valid_s[2]),
    .out_ready(out_ready_s[2]), .result(res_s[2]), .cout(cout_s[2]),
    .ovf(ovf_s[2]), .zero(zero_s[2]));

  addsub_seq #(.WIDTH(12), .CHUNK(3)) u_w12c3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[3]), .in_ready(in_ready_s[3]),
    .a(a_s[3][11:0]), .b(b_s[3][11:0]), .sub(sub_s[3]), .out_valid(out_valid_s[3]),
    .out_ready(out_ready_s[3]), .result(res_s[3][11:0]), .cout(cout_s[3]),
    .ovf(ovf_s[3]), .zero(zero_s[3]));
  assign res_s[3][15:12] = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic scramble(input int k);
    a_s[k]   = 16'($urandom);
    b_s[k]   = 16'($urandom);
    sub_s[k] = 1'($urandom);
  endtask

  // Independent reference: signed range check for ovf, unsigned compare for carry/borrow.
  function automatic logic [18:0] model(input int w, input logic [15:0] av,
                                        input logic [15:0] bv, input logic sv);
    int unsigned mask, ua, ub, ur;
    int          sa, sb, s;
    logic        co, ov;
    mask = (32'd1 << w) - 32'd1;
    ua   = 32'(av) & mask;
    ub   = 32'(bv) & mask;
    sa   = (ua >= (32'd1 << (w - 1))) ? int'(ua) - (1 << w) : int'(ua);
    sb   = (ub >= (32'd1 << (w - 1))) ? int'(ub) - (1 << w) : int'(ub);
    s    = sv ? sa - sb : sa + sb;
    ov   = (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
    ur   = sv ? ((ua - ub) & mask) : ((ua + ub) & mask);
    co   = sv ? (ua >= ub) : ((ua + ub) > mask);
    return {ur == 0, ov, co, 16'(ur)};
  endfunction

  // One full transaction on instance k; entered and left at a falling edge.
  task automatic run_txn(input int k, input int n, input logic [15:0] av, input logic [15:0] bv,
                         input logic sv, input int pre, input int hold,
                         output logic [15:0] r, output logic co, output logic ov, output logic z);
    int guard;
    int lat;
    repeat (pre) begin
      scramble(k);
      @(negedge clk);
    end
    a_s[k] = av; b_s[k] = bv; sub_s[k] = sv; in_valid_s[k] = 1'b1;
    guard = 0;
    while (in_ready_s[k] !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready_s[k]);
    end
    @(negedge clk);
    in_valid_s[k] = 1'($urandom);
    scramble(k);
    lat = 0;
    while (out_valid_s[k] !== 1'b1 && lat < 40) begin
      chk("busy_in_ready", 32'(in_ready_s[k]), 0);
      @(negedge clk);
      lat++;
      in_valid_s[k] = 1'($urandom);
      scramble(k);
    end
    chk("latency", lat, n);
    r = res_s[k]; co = cout_s[k]; ov = ovf_s[k]; z = zero_s[k];
    repeat (hold) begin
      @(negedge clk);
      in_valid_s[k] = 1'($urandom);
      scramble(k);
      chk("hold_out_valid", 32'(out_valid_s[k]), 1);
      chk("hold_in_ready",  32'(in_ready_s[k]), 0);
      chk("hold_result",    32'(res_s[k]), 32'(r));
      chk("hold_flags",     32'({cout_s[k], ovf_s[k], zero_s[k]}), 32'({co, ov, z}));
    end
    out_ready_s[k] = 1'b1;
    in_valid_s[k]  = 1'b0;
    @(negedge clk);
    out_ready_s[k] = 1'b0;
    chk("post_in_ready",  32'(in_ready_s[k]), 1);
    chk("post_out_valid", 32'(out_valid_s[k]), 0);
  endtask

  vec_t vecs [13];

  initial begin
    logic [15:0] r;
    logic        co, ov, z;
    logic [18:0] m;
    int          wid [NI];
    int          nch [NI];

    vecs[0]  = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{8'hFF, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0};
    wid = '{8, 16, 16, 12};
    nch = '{2, 16, 1, 4};

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0; sub_s[k] = 1'b0;
      a_s[k] = '0; b_s[k] = '0;
    end

    // Reset values, including across a clock edge while held in reset
    #2;
    chk("rst_in_ready",  32'(in_ready_s[0]), 0);
    chk("rst_out_valid", 32'(out_valid_s[0]), 0);
    chk("rst_result",    32'(res_s[0]), 0);
    chk("rst_flags",     32'({cout_s[0], ovf_s[0], zero_s[0]}), 0);
    @(negedge clk);
    chk("rst_in_ready_edge", 32'(in_ready_s[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready",  32'(in_ready_s[0]), 1);
    chk("release_out_valid", 32'(out_valid_s[0]), 0);

    for (int i = 0; i < 13; i++) begin
      run_txn(0, 2, 16'(vecs[i].a), 16'(vecs[i].b), vecs[i].sub, 0, 0, r, co, ov, z);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("vec%0d_cout", i),   32'(co), 32'(vecs[i].co));
      chk($sformatf("vec%0d_ovf", i),    32'(ov), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_zero", i),   32'(z),  32'(vecs[i].z));
    end

    // Backpressure: result held for 5 cycles while inputs churn
    run_txn(0, 2, 16'h0005, 16'h0003, 1'b1, 0, 5, r, co, ov, z);
    chk("bp_result", 32'(r), 32'h02);
    chk("bp_flags",  32'({co, ov, z}), 32'(3'b100));

    // Reset mid-BUSY aborts the transaction
    chk("pre_abort_in_ready", 32'(in_ready_s[0]), 1);
    a_s[0] = 16'h0010; b_s[0] = 16'h0020; sub_s[0] = 1'b0; in_valid_s[0] = 1'b1;
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready",  32'(in_ready_s[0]), 0);
    chk("abort_out_valid", 32'(out_valid_s[0]), 0);
    chk("abort_result",    32'(res_s[0]), 0);
    chk("abort_flags",     32'({cout_s[0], ovf_s[0], zero_s[0]}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release_in_ready", 32'(in_ready_s[0]), 1);
    repeat (3) begin
      chk("abort_no_result", 32'(out_valid_s[0]), 0);
      @(negedge clk);
    end
    run_txn(0, 2, 16'h0010, 16'h0010, 1'b1, 0, 0, r, co, ov, z);
    chk("fresh_result", 32'(r), 0);
    chk("fresh_flags",  32'({co, ov, z}), 32'(3'b101));

    // Randomized sweeps on the other configurations
    for (int k = 1; k < NI; k++) begin
      for (int j = 0; j < 1000; j++) begin
        logic [15:0] av, bv;
        logic        sv;
        av = 16'($urandom);
        bv = 16'($urandom);
        sv = 1'($urandom);
        run_txn(k, nch[k], av, bv, sv, $urandom_range(0, 3), $urandom_range(0, 3), r, co, ov, z);
        m = model(wid[k], av, bv, sv);
        chk($sformatf("rand_k%0d_result", k), 32'(r),  32'(m[15:0]));
        chk($sformatf("rand_k%0d_cout", k),   32'(co), 32'(m[16]));
        chk($sformatf("rand_k%0d_ovf", k),    32'(ov), 32'(m[17]));
        chk($sformatf("rand_k%0d_zero", k),   32'(z),  32'(m[18]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
